// File: rtl/codebreaker_timer_sequencer.sv
// codebreaker_timer_sequencer
//
// Avalon-MM master that runs the 6-register interval timer (16-bit data, 3-bit word
// address). It programs the period, starts the timer in continuous mode and clears
// status on each irq. It counts the serviced ticks and stops the timer when the
// requested tick count is reached or when the host asks it to stop.
//
// Optional feature, macro SNAPSHOT_EN:
//   defined   - after each status clear, latch the timer counter (write addr 4), read
//               both halves (addr 4, 5) and publish them atomically on snapshot.
//   undefined - no snapshot states; snapshot is tied to 0.
//
// Parameters:
//   READ_LATENCY  cycles from read-beat accept to valid avm_readdata (>= 1)
//   MIN_PERIOD    smallest period ever written; smaller cfg_period is clamped up
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_start             pulse: program and start (ignored while busy)
//   cfg_stop              pulse: stop the timer (ignored while idle)
//   cfg_period            timer load value, sampled on accepted cfg_start
//   cfg_ticks             tick limit (0 = run until cfg_stop), sampled on accepted cfg_start
//   busy                  high from accepted cfg_start until back in idle
//   tick_pulse            one-cycle pulse per serviced timeout
//   tick_count            ticks since last start, wraps
//   done                  one-cycle pulse when the stop write completes
//   snapshot              last counter snapshot (0 without SNAPSHOT_EN)
//   avm_*                 Avalon-MM master port to the timer's s1 slave
//   timer_irq             timer interrupt, level
module codebreaker_timer_sequencer #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MIN_PERIOD   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [31:0] cfg_period,
  input  logic [15:0] cfg_ticks,
  output logic        busy,
  output logic        tick_pulse,
  output logic [15:0] tick_count,
  output logic        done,
  output logic [31:0] snapshot,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq
);

  localparam logic [31:0] MinPeriod   = 32'(MIN_PERIOD);
  localparam logic [15:0] CtrlStart   = 16'h0007;  // START | CONT | ITO
  localparam logic [15:0] CtrlStop    = 16'h0008;  // STOP, ITO and CONT cleared
  localparam logic [2:0]  AddrStatus  = 3'd0;
  localparam logic [2:0]  AddrControl = 3'd1;
  localparam logic [2:0]  AddrPeriodL = 3'd2;
  localparam logic [2:0]  AddrPeriodH = 3'd3;
`ifdef SNAPSHOT_EN
  localparam logic [2:0]  AddrSnapL   = 3'd4;
  localparam logic [2:0]  AddrSnapH   = 3'd5;
  localparam int unsigned RdCntW      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
`endif

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StWaitIrq,
    StClrSts,
    StWrStop
`ifdef SNAPSHOT_EN
    ,
    StSnapWr,
    StSnapRl,
    StSnapRh
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [15:0] ticks_q, ticks_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic        stop_req_q, stop_req_d;
  logic        tick_pulse_q, tick_pulse_d;
  logic        done_q, done_d;

  logic        cs_q, cs_d;
  logic [2:0]  addr_q, addr_d;
  logic        wr_n_q, wr_n_d;
  logic [15:0] wdata_q, wdata_d;

  logic        accept;
  logic        stop_any;
  logic [15:0] tick_inc;
  logic        limit_hit_inc;
  logic [31:0] period_clamped;

  assign accept         = cs_q & ~avm_waitrequest;
  // A stop pulse arriving in the same cycle as a decision counts as already latched.
  assign stop_any       = stop_req_q | cfg_stop;
  assign tick_inc       = tick_count_q + 16'd1;
  assign limit_hit_inc  = (ticks_q != 16'd0) && (tick_inc == ticks_q);
  assign period_clamped = (cfg_period < MinPeriod) ? MinPeriod : cfg_period;

`ifdef SNAPSHOT_EN
  logic              rd_pend_q, rd_pend_d;
  logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_capture;
  logic              limit_hit_cur;
  logic [15:0]       snap_lo_q, snap_hi_q;
  logic              snap_upd_q;
  logic [31:0]       snapshot_q;

  assign rd_capture    = rd_pend_q && (rd_cnt_q == '0);
  // tick_count has already been bumped by the time the snapshot reads finish.
  assign limit_hit_cur = (ticks_q != 16'd0) && (tick_count_q == ticks_q);
`endif

  // Sequencer next state.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    ticks_d      = ticks_q;
    tick_count_d = tick_count_q;
    stop_req_d   = stop_req_q;
    tick_pulse_d = 1'b0;
    done_d       = 1'b0;

    if (state_q != StIdle && cfg_stop) begin
      stop_req_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d      = StWrPl;
          period_d     = period_clamped;
          ticks_d      = cfg_ticks;
          tick_count_d = 16'd0;
        end
      end
      StWrPl: begin
        if (accept) state_d = stop_any ? StWrStop : StWrPh;
      end
      StWrPh: begin
        if (accept) state_d = stop_any ? StWrStop : StWrCtrl;
      end
      StWrCtrl: begin
        if (accept) state_d = stop_any ? StWrStop : StWaitIrq;
      end
      StWaitIrq: begin
        // irq wins over a simultaneous stop; the stop stays latched for after the clear.
        if (timer_irq) begin
          state_d = StClrSts;
        end else if (stop_any) begin
          state_d = StWrStop;
        end
      end
      StClrSts: begin
        if (accept) begin
          tick_count_d = tick_inc;
          tick_pulse_d = 1'b1;
          if (stop_any) begin
            state_d = StWrStop;
          end else begin
`ifdef SNAPSHOT_EN
            state_d = StSnapWr;
`else
            state_d = limit_hit_inc ? StWrStop : StWaitIrq;
`endif
          end
        end
      end
      StWrStop: begin
        if (accept) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`ifdef SNAPSHOT_EN
      StSnapWr: begin
        if (accept) state_d = stop_any ? StWrStop : StSnapRl;
      end
      StSnapRl: begin
        if (rd_capture) state_d = stop_any ? StWrStop : StSnapRh;
      end
      StSnapRh: begin
        if (rd_capture) state_d = (stop_any || limit_hit_cur) ? StWrStop : StWaitIrq;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Once the stop write is under way (or the sequencer is idle) there is nothing to remember.
    if (state_d == StIdle || state_d == StWrStop) begin
      stop_req_d = 1'b0;
    end
  end

  // Bus request registers: a new beat is launched on entry to a beat state and held until
  // accepted. Accept drops chipselect; a launch in the same cycle re-raises it.
  always_comb begin
    cs_d    = cs_q;
    addr_d  = addr_q;
    wr_n_d  = wr_n_q;
    wdata_d = wdata_q;

    if (accept) begin
      cs_d = 1'b0;
    end

    if (state_d != state_q) begin
      case (state_d)
        StWrPl: begin
          cs_d = 1'b1; addr_d = AddrPeriodL; wr_n_d = 1'b0; wdata_d = period_d[15:0];
        end
        StWrPh: begin
          cs_d = 1'b1; addr_d = AddrPeriodH; wr_n_d = 1'b0; wdata_d = period_d[31:16];
        end
        StWrCtrl: begin
          cs_d = 1'b1; addr_d = AddrControl; wr_n_d = 1'b0; wdata_d = CtrlStart;
        end
        StClrSts: begin
          cs_d = 1'b1; addr_d = AddrStatus; wr_n_d = 1'b0; wdata_d = 16'h0000;
        end
        StWrStop: begin
          cs_d = 1'b1; addr_d = AddrControl; wr_n_d = 1'b0; wdata_d = CtrlStop;
        end
`ifdef SNAPSHOT_EN
        StSnapWr: begin
          cs_d = 1'b1; addr_d = AddrSnapL; wr_n_d = 1'b0; wdata_d = 16'h0000;
        end
        StSnapRl: begin
          cs_d = 1'b1; addr_d = AddrSnapL; wr_n_d = 1'b1; wdata_d = 16'h0000;
        end
        StSnapRh: begin
          cs_d = 1'b1; addr_d = AddrSnapH; wr_n_d = 1'b1; wdata_d = 16'h0000;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      period_q     <= 32'd0;
      ticks_q      <= 16'd0;
      tick_count_q <= 16'd0;
      stop_req_q   <= 1'b0;
      tick_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      cs_q         <= 1'b0;
      addr_q       <= 3'd0;
      wr_n_q       <= 1'b1;
      wdata_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      ticks_q      <= ticks_d;
      tick_count_q <= tick_count_d;
      stop_req_q   <= stop_req_d;
      tick_pulse_q <= tick_pulse_d;
      done_q       <= done_d;
      cs_q         <= cs_d;
      addr_q       <= addr_d;
      wr_n_q       <= wr_n_d;
      wdata_q      <= wdata_d;
    end
  end

`ifdef SNAPSHOT_EN
  // Read-data wait: count READ_LATENCY cycles after a read accept, then capture.
  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_cnt_d  = rd_cnt_q;
    if (accept && wr_n_q) begin
      rd_pend_d = 1'b1;
      rd_cnt_d  = RdCntW'(READ_LATENCY - 1);
    end else if (rd_pend_q) begin
      if (rd_cnt_q == '0) begin
        rd_pend_d = 1'b0;
      end else begin
        rd_cnt_d = rd_cnt_q - 1'b1;
      end
    end
  end

  // snapshot changes only once both halves are held, so it is never half-updated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_cnt_q   <= '0;
      snap_lo_q  <= 16'd0;
      snap_hi_q  <= 16'd0;
      snap_upd_q <= 1'b0;
      snapshot_q <= 32'd0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_cnt_q   <= rd_cnt_d;
      snap_upd_q <= 1'b0;
      if (rd_capture && state_q == StSnapRl) begin
        snap_lo_q <= avm_readdata;
      end
      if (rd_capture && state_q == StSnapRh) begin
        snap_hi_q  <= avm_readdata;
        snap_upd_q <= 1'b1;
      end
      if (snap_upd_q) begin
        snapshot_q <= {snap_hi_q, snap_lo_q};
      end
    end
  end

  assign snapshot = snapshot_q;
`else
  assign snapshot = 32'h0000_0000;
`endif

  assign busy           = (state_q != StIdle);
  assign tick_pulse     = tick_pulse_q;
  assign tick_count     = tick_count_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wr_n_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_codebreaker_timer_sequencer.sv
// Bench for codebreaker_timer_sequencer. A behavioural timer slave answers the bus,
// raises irq on timeout and pushes the beats the sequencer should issue onto a
// scoreboard; each accepted beat is popped and compared.
module tb_codebreaker_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic [15:0] cfg_ticks = 16'd0;
  logic        busy;
  logic        tick_pulse;
  logic [15:0] tick_count;
  logic        done;
  logic [31:0] snapshot;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] avm_readdata = 16'd0;
  logic        timer_irq = 1'b0;

  always #5 clk = ~clk;

  codebreaker_timer_sequencer #(
    .READ_LATENCY(1),
    .MIN_PERIOD  (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_period     (cfg_period),
    .cfg_ticks      (cfg_ticks),
    .busy           (busy),
    .tick_pulse     (tick_pulse),
    .tick_count     (tick_count),
    .done           (done),
    .snapshot       (snapshot),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .timer_irq      (timer_irq)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] sb[$];

  // Timer slave model state.
  logic [31:0] tmr_period = 32'd0;
  int          tmr_cnt = 0;
  bit          tmr_run = 1'b0;
  int          served = 0;
  int          lim = 0;
  bit          stop_now = 1'b0;
  bit          stop_with_irq = 1'b0;
  int          stall_req = 0;
  int          stall_left = 0;
  int          stall_seen = 0;
  bit          rd_pend = 1'b0;
  logic [15:0] rd_val = 16'd0;
  bit          hold_valid = 1'b0;
  logic [19:0] hold = 20'd0;

  // Output monitors.
  int tick_n = 0;
  int done_n = 0;
  int tick_base = 0;
  int done_base = 0;
  int tick_times[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Read beats carry no meaningful write data.
  function automatic logic [19:0] beat(input logic wr_n, input logic [2:0] a, input logic [15:0] d);
    return {wr_n, a, wr_n ? 16'h0000 : d};
  endfunction

  initial begin : slave
    logic [19:0] cur;
    logic [19:0] want;
    forever begin
      @(negedge clk);
      if (reset_n && tick_pulse) begin
        tick_n++;
        tick_times.push_back(cyc);
      end
      if (reset_n && done) done_n++;

      cfg_stop = 1'b0;
      if (rd_pend) begin
        avm_readdata = rd_val;
        rd_pend      = 1'b0;
      end
      if (!reset_n) begin
        tmr_run         = 1'b0;
        timer_irq       = 1'b0;
        sb.delete();
        hold_valid      = 1'b0;
        stall_left      = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (tmr_run) begin
          if (tmr_cnt == 0) begin
            tmr_cnt   = int'(tmr_period);
            timer_irq = 1'b1;
            served++;
            sb.push_back(beat(1'b0, 3'd0, 16'h0000));
            if (stop_with_irq) begin
              stop_with_irq = 1'b0;
              cfg_stop      = 1'b1;
              sb.push_back(beat(1'b0, 3'd1, 16'h0008));
            end else begin
`ifdef SNAPSHOT_EN
              sb.push_back(beat(1'b0, 3'd4, 16'h0000));
              sb.push_back(beat(1'b1, 3'd4, 16'h0000));
              sb.push_back(beat(1'b1, 3'd5, 16'h0000));
`endif
              if (lim != 0 && served == lim) sb.push_back(beat(1'b0, 3'd1, 16'h0008));
            end
          end else begin
            tmr_cnt--;
          end
        end
        if (stop_now) begin
          stop_now = 1'b0;
          cfg_stop = 1'b1;
          sb.push_back(beat(1'b0, 3'd1, 16'h0008));
        end

        avm_waitrequest = 1'b0;
        if (avm_chipselect) begin
          cur = beat(avm_write_n, avm_address, avm_writedata);
          if (!hold_valid) begin
            hold       = cur;
            hold_valid = 1'b1;
            if (!avm_write_n && avm_address == 3'd3 && stall_req > 0) begin
              stall_left = stall_req;
              stall_req  = 0;
            end
          end else begin
            check_eq("hold_stable", 32'(cur), 32'(hold));
          end
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
            stall_seen++;
          end else begin
            hold_valid = 1'b0;
            if (sb.size() == 0) begin
              check_eq("beat_unexpected", 32'(cur), 32'hFFFF_FFFF);
            end else begin
              want = sb.pop_front();
              check_eq("beat", 32'(cur), 32'(want));
            end
            if (!avm_write_n) begin
              case (avm_address)
                3'd0: timer_irq = 1'b0;
                3'd1: begin
                  if (avm_writedata[3]) begin
                    tmr_run = 1'b0;
                  end else if (avm_writedata[2]) begin
                    tmr_run = 1'b1;
                    tmr_cnt = int'(tmr_period);
                  end
                end
                3'd2: tmr_period[15:0] = avm_writedata;
                3'd3: tmr_period[31:16] = avm_writedata;
                default: ;
              endcase
            end else begin
              rd_pend = 1'b1;
              rd_val  = (avm_address == 3'd4) ? 16'h1234 : 16'h0000;
            end
          end
        end else if (hold_valid) begin
          check_eq("cs_held", 32'(avm_chipselect), 32'd1);
          hold_valid = 1'b0;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
    check_eq({tag, "_write_n"}, 32'(avm_write_n), 32'd1);
    check_eq({tag, "_addr"}, 32'(avm_address), 32'd0);
    check_eq({tag, "_wdata"}, 32'(avm_writedata), 32'd0);
    check_eq({tag, "_tick_count"}, 32'(tick_count), 32'd0);
    check_eq({tag, "_tick_pulse"}, 32'(tick_pulse), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_snapshot"}, snapshot, 32'd0);
  endtask

  task automatic start_run(input logic [31:0] per, input logic [15:0] tk);
    logic [31:0] p;
    p = (per < 32'd8) ? 32'd8 : per;
    @(negedge clk);
    sb.push_back(beat(1'b0, 3'd2, p[15:0]));
    sb.push_back(beat(1'b0, 3'd3, p[31:16]));
    sb.push_back(beat(1'b0, 3'd1, 16'h0007));
    lim        = int'(tk);
    served     = 0;
    tick_base  = tick_n;
    done_base  = done_n;
    tick_times.delete();
    cfg_period = per;
    cfg_ticks  = tk;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_n == done_base; i++) @(posedge clk);
    check_eq({tag, "_done"}, done_n - done_base, 32'd1);
    @(negedge clk);
    check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_sb_drained"}, sb.size(), 32'd0);
  endtask

  task automatic wait_ticks(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && (tick_n - tick_base) < n; i++) @(posedge clk);
    check_eq({tag, "_ticks_seen"}, tick_n - tick_base, n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    @(negedge clk);
    reset_n = 1'b1;

    // Program and run: period 0x63 -> tick every 100 cycles, stop after 3.
    start_run(32'h0000_0063, 16'd3);
    wait_done("t1", 1000);
    check_eq("t1_tick_count", 32'(tick_count), 32'd3);
    check_eq("t1_pulses", tick_n - tick_base, 32'd3);
    if (tick_times.size() >= 3) begin
      check_eq("t1_spacing_a", tick_times[1] - tick_times[0], 32'd100);
      check_eq("t1_spacing_b", tick_times[2] - tick_times[1], 32'd100);
    end else begin
      check_eq("t1_tick_times", tick_times.size(), 32'd3);
    end
`ifdef SNAPSHOT_EN
    check_eq("t1_snapshot", snapshot, 32'h0000_1234);
`else
    check_eq("t1_snapshot", snapshot, 32'h0000_0000);
`endif
    repeat (3) @(negedge clk);
    check_eq("t1_done_once", done_n - done_base, 32'd1);

    // Waitrequest held for 5 cycles on the period-high write.
    @(posedge clk);
    stall_req  = 5;
    stall_seen = 0;
    start_run(32'd20, 16'd1);
    wait_done("t2", 300);
    check_eq("t2_stall_cycles", stall_seen, 32'd5);
    check_eq("t2_tick_count", 32'(tick_count), 32'd1);

    // Host stop between ticks 2 and 3.
    start_run(32'd40, 16'd0);
    wait_ticks("t3", 2, 300);
    repeat (5) @(posedge clk);
    stop_now = 1'b1;
    wait_done("t3", 100);
    check_eq("t3_tick_count", 32'(tick_count), 32'd2);

    // Host stop in the same cycle as the third irq.
    start_run(32'd30, 16'd0);
    wait_ticks("t4", 2, 300);
    stop_with_irq = 1'b1;
    wait_done("t4", 200);
    check_eq("t4_tick_count", 32'(tick_count), 32'd3);

    // Period clamp and cfg_start while busy.
    start_run(32'd2, 16'd2);
    @(negedge clk);
    cfg_period = 32'd50;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("t5", 200);
    check_eq("t5_tick_count", 32'(tick_count), 32'd2);
    if (tick_times.size() >= 2) begin
      check_eq("t5_spacing", tick_times[1] - tick_times[0], 32'd9);
    end else begin
      check_eq("t5_tick_times", tick_times.size(), 32'd2);
    end

    // Reset while waiting for irq, then a fresh run.
    start_run(32'd50, 16'd0);
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset("rst1");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_run(32'd10, 16'd1);
    wait_done("t6", 200);
    check_eq("t6_tick_count", 32'(tick_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
